// File: rtl/uart_rx_frontend.sv
// UART receive front end: pin synchroniser, 16x oversampled frame recovery and FWFT byte FIFO.
// Define UART_RX_PARITY_EN for 8E1 frames with a sticky parity error flag (default is 8N1).
module uart_rx_frontend #(
  parameter int unsigned CLK_DIV    = 651,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        UART_RX,
  output logic [7:0]                  rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [$clog2(FIFO_DEPTH):0] rx_count,
  output logic                        frame_err,
  output logic                        overrun,
  output logic                        parity_err,
  input  logic                        err_clr
);

  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam logic [15:0] DivMax = 16'(CLK_DIV - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBreakWait} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreakWait} state_e;
`endif

  // Two-flop synchroniser, idle-high reset so no false start edge leaves reset.
  logic rx_meta_q, rx_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      rx_meta_q <= UART_RX;
      rx_s      <= rx_meta_q;
    end
  end

  // Oversample tick generator.
  logic [15:0] div_q;
  logic        tick;

  assign tick = (div_q == DivMax);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 16'd1;
    end
  end

  // Frame recovery FSM.
  state_e      state_q, state_d;
  logic [3:0]  os_cnt_q, os_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [1:0]  samp_q, samp_d;
  logic        vote;
  logic        push_req;
  logic        frame_set;
  logic        par_set;

  // Samples from the two previous ticks plus the live one form the 3-sample window.
  assign vote = (samp_q[1] & samp_q[0]) | (samp_q[1] & rx_s) | (samp_q[0] & rx_s);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      os_cnt_q  <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      samp_q    <= 2'b11;
    end else begin
      state_q   <= state_d;
      os_cnt_q  <= os_cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      samp_q    <= samp_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    os_cnt_d  = os_cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    samp_d    = samp_q;
    push_req  = 1'b0;
    frame_set = 1'b0;
    par_set   = 1'b0;
    if (tick) begin
      samp_d = {samp_q[0], rx_s};
      if (state_q != StIdle) begin
        os_cnt_d = os_cnt_q + 4'd1;
      end
      unique case (state_q)
        StIdle: begin
          if (!rx_s) begin
            os_cnt_d = 4'd0;
            state_d  = StStart;
          end
        end
        StStart: begin
          if (os_cnt_q == 4'd9 && vote) begin
            state_d = StIdle;
          end else if (os_cnt_q == 4'd15) begin
            state_d   = StData;
            bit_idx_d = 3'd0;
          end
        end
        StData: begin
          if (os_cnt_q == 4'd9) begin
            shreg_d = {vote, shreg_q[7:1]};
          end
          if (os_cnt_q == 4'd15) begin
            bit_idx_d = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = StParity;
`else
              state_d = StStop;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (os_cnt_q == 4'd9) begin
            par_set = (^shreg_q) ^ vote;
          end
          if (os_cnt_q == 4'd15) begin
            state_d = StStop;
          end
        end
`endif
        StStop: begin
          // Leave half a bit early so the next start edge is not missed.
          if (os_cnt_q == 4'd9) begin
            if (vote) begin
              push_req = 1'b1;
              state_d  = StIdle;
            end else begin
              frame_set = 1'b1;
              state_d   = StBreakWait;
            end
          end
        end
        StBreakWait: begin
          if (rx_s) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // First-word-fall-through FIFO with one extra pointer bit for full/empty.
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic        full, pop, push, overrun_set;

  assign rx_valid    = (wptr_q != rptr_q);
  assign full        = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  assign pop         = rx_valid && rx_ready;
  assign push        = push_req && (!full || pop);
  assign overrun_set = push_req && full && !pop;
  assign rx_count    = wptr_q - rptr_q;
  assign rx_data     = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_q[wptr_q[AW-1:0]] <= shreg_q;
        wptr_q                <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
    end
  end

  // Sticky flags: a set event in the same cycle as err_clr wins.
  logic frame_err_q, overrun_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= frame_set | (frame_err_q & ~err_clr);
      overrun_q   <= overrun_set | (overrun_q & ~err_clr);
    end
  end

  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

`ifdef UART_RX_PARITY_EN
  logic parity_err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= par_set | (parity_err_q & ~err_clr);
    end
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx_frontend.md
# uart_rx_frontend

Serial receive front end feeding the memory-mapped UART peripheral's receive-data register. It does the following:
- Synchronises the raw `UART_RX` pin and generates its own 16x oversampling tick.
- Recovers 8N1 frames using majority-vote sampling.
- Queues received bytes in a small first-word-fall-through FIFO.
- Presents bytes through a valid/ready handshake, with sticky framing, overrun and (optionally) parity error flags for the peripheral to expose.

## Interface
- `CLK_DIV`, default 651: `clk` cycles per oversample tick (100 MHz / 9600 / 16). Legal range 2..65535.
- `FIFO_DEPTH`, default 4: number of byte entries. Must be a power of two, 2..16.
- `clk`, in, 1: system clock; every register is clocked on its rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `UART_RX`, in, 1: raw serial line. Idle is high.
- `rx_data`, out, 8: FIFO head byte. Meaningful only while `rx_valid`=1.
- `rx_valid`, out, 1: FIFO is not empty.
- `rx_ready`, in, 1: consumer pop. A byte is popped on a clock edge where `rx_valid` and `rx_ready` are both 1.
- `rx_count`, out, clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `frame_err`, out, 1: sticky. Set when a stop bit is sampled low.
- `overrun`, out, 1: sticky. Set when a byte completes while the FIFO is full.
- `parity_err`, out, 1: sticky. See Configuration.
- `err_clr`, in, 1: one-cycle pulse that clears all sticky flags.

## Operation
- **Synchroniser**
  - Two flops on `UART_RX`, both reset to 1.
  - The FSM sees only the second flop, `rx_s`.
- **Tick generator**
  - Free-running counter 0..CLK_DIV-1, reset to 0.
  - `tick` is a one-cycle pulse when the counter equals CLK_DIV-1; the counter then wraps to 0.
- **FSM states**
  - States are IDLE, START, DATA, PARITY (macro only), STOP and BREAK_WAIT. `os_cnt` is 4 bits; `bit_idx` is 3 bits.
  - The FSM advances only on `tick`, and `os_cnt` increments on every tick outside IDLE.
  - Each tick samples `rx_s` into a 3-sample shift register. The vote at `os_cnt`=9 is the majority of the samples taken at 7, 8 and 9.
  - IDLE: on a tick with `rx_s`=0, set `os_cnt`=0 and go to START.
  - START: at `os_cnt`=9, a vote of 1 is a glitch and returns to IDLE; nothing is recorded. At `os_cnt`=15, go to DATA with `bit_idx`=0.
  - DATA: at 9, shift the vote into bit 7 of the shift register (LSB first, shift right). At 15, increment `bit_idx`; after bit 7 go to PARITY if the macro is defined, otherwise STOP.
  - STOP: at 9, a vote of 1 pushes the byte and returns to IDLE, half a bit early, so the next start edge can be found.
  - STOP: at 9, a vote of 0 sets `frame_err`, discards the byte and goes to BREAK_WAIT.
  - BREAK_WAIT: on a tick with `rx_s`=1, go to IDLE.
- **FIFO**
  - Read and write pointers are clog2(FIFO_DEPTH)+1 bits and wrap naturally.
  - Empty when the pointers are equal. Full when the index bits are equal and the MSBs differ.
  - Push while full with no pop in the same cycle: byte dropped, `overrun` set, contents unchanged.
  - Push and pop in the same cycle while full: both happen, no overrun, count unchanged.
  - Push and pop in the same cycle while empty: not possible, because `rx_valid`=0.
  - Pop while empty: ignored.
- **Sticky flags**
  - A set event and `err_clr` in the same cycle: set wins.

## Timing
- Reset values:
  - Outputs: `rx_valid`=0, `rx_count`=0, `rx_data`=8'h00, all error flags 0.
  - Internal: FSM in IDLE, pointers 0.
- Pin-to-FSM latency is 2 clk, plus up to CLK_DIV clk to the next tick.
- Start-edge detection jitter is at most 1 tick (1/16 bit).
- A byte is written at the clock edge of the STOP `os_cnt`=9 tick. `rx_valid` and `rx_data` are valid the following cycle.
- `rx_data` is combinational from the FIFO head and changes in the cycle after a pop.
- Reset asserted mid-frame aborts immediately. The FIFO is emptied, and reception resumes with the next falling edge after reset deasserts.
- A line held low continuously produces one `frame_err`, then stays in BREAK_WAIT with no further pushes.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - The frame is 1 start bit, 8 data bits, 1 even-parity bit, 1 stop bit.
  - The PARITY state votes at `os_cnt`=9 and moves to STOP at 15.
  - If the XOR of the data bits and the parity bit is 1, `parity_err` is set; the byte is still pushed if the stop bit is good.
- Not defined:
  - The PARITY state and its logic are absent, and the frame is 8N1.
  - `parity_err` is tied to 0.

## Test plan
All scenarios use `CLK_DIV`=4, so one bit is 64 clk.
- Reset, then send 8N1 8'hA5 with `rx_ready`=0 → `rx_valid`=1, `rx_data`=8'hA5, `rx_count`=1, all flags 0.
- Send 5 bytes 8'h01..8'h05 back-to-back with `rx_ready`=0 (`FIFO_DEPTH`=4) → `rx_count`=4, `overrun`=1; popping yields 01, 02, 03, 04, then `rx_valid`=0.
- Low glitch of 20 clk on an idle line → START aborts, no push, `rx_count`=0, `frame_err`=0.
- Send 8'h3C with the stop bit driven low, then hold the line low for 3 bit times, release, and send 8'h7E → `frame_err`=1, exactly one entry, 8'h7E; `err_clr` pulse → `frame_err`=0.
- FIFO full, and a new byte completes in the same cycle as a pop → `rx_count` stays 4, `overrun`=0, the new byte appears last.
- With `UART_RX_PARITY_EN`: send 8'h03 with parity bit 1 → byte 8'h03 pushed, `parity_err`=1.
